// File: rtl/alu_writeback_queue.sv
// In-order result queue between the ALU and the register-file write port, with
// youngest-first forwarding of queued results to two source-register lookups.
module alu_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       in_zero,
  input  logic [ADDR_W-1:0]          in_dest,
  output logic                       wr_en,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       zero_flag,
  input  logic [ADDR_W-1:0]          rd_addr_a,
  output logic                       fwd_hit_a,
  output logic [DATA_W-1:0]          fwd_data_a,
  input  logic [ADDR_W-1:0]          rd_addr_b,
  output logic                       fwd_hit_b,
  output logic [DATA_W-1:0]          fwd_data_b,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              zero_q, zero_d;
  logic              push, pop;
  logic [PTR_W-1:0]  fwd_idx;

  // Ready depends only on registered occupancy, never on wr_ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign wr_en     = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = wr_en & wr_ready;
  assign wr_addr   = dest_q[rd_ptr_q];
  assign wr_data   = data_q[rd_ptr_q];
  assign zero_flag = zero_q;
  assign count     = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    zero_d   = zero_q;
    vld_d    = vld_q;
    if (pop) begin
      rd_ptr_d         = rd_ptr_q + 1'b1;
      vld_d[rd_ptr_q]  = 1'b0;
    end
    if (push) begin
      wr_ptr_d         = wr_ptr_q + 1'b1;
      vld_d[wr_ptr_q]  = 1'b1;
      zero_d           = in_zero;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      zero_q   <= 1'b0;
      vld_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      zero_q   <= zero_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= in_result;
      dest_q[wr_ptr_q] <= in_dest;
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    fwd_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if (vld_q[fwd_idx] && (rd_addr_a != '0) && (dest_q[fwd_idx] == rd_addr_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = data_q[fwd_idx];
      end
      if (vld_q[fwd_idx] && (rd_addr_b != '0) && (dest_q[fwd_idx] == rd_addr_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_queue.sv
// Directed bench for alu_writeback_queue: reset, single push, fill/overflow,
// push+pop at full with pointer wrap, forwarding priority and zero flag.
module tb_alu_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic [4:0]  in_dest;
  logic        wr_en;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        zero_flag;
  logic [4:0]  rd_addr_a;
  logic        fwd_hit_a;
  logic [31:0] fwd_data_a;
  logic [4:0]  rd_addr_b;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_b;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  alu_writeback_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_dest(in_dest),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .zero_flag(zero_flag),
    .rd_addr_a(rd_addr_a), .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .rd_addr_b(rd_addr_b), .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [31:0] res, input logic [4:0] dest, input logic z);
    in_valid  = 1'b1;
    in_result = res;
    in_dest   = dest;
    in_zero   = z;
  endtask

  logic [4:0] exp_head;
  logic [4:0] next_push;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_dest = '0;
    wr_ready = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_zero", 32'(zero_flag), 0);
    #10 rst_n = 1'b1;
    tick();

    // Single push, drained immediately
    push_in(32'h0000_00A5, 5'd3, 1'b0);
    wr_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_wr_en", 32'(wr_en), 1);
    check("single_addr", 32'(wr_addr), 3);
    check("single_data", wr_data, 32'hA5);
    check("single_count", 32'(count), 1);
    tick();
    check("single_drained", 32'(count), 0);
    check("single_wr_en_lo", 32'(wr_en), 0);

    // Fill with write port stalled
    wr_ready = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      push_in(32'h100 + 32'(d), 5'(d), 1'b0);
      tick();
      check("fill_head_stable", wr_data, 32'h101);
    end
    check("fill_count", 32'(count), 4);
    check("fill_in_ready", 32'(in_ready), 0);
    push_in(32'h999, 5'd5, 1'b0);
    tick();
    check("overflow_ignored", 32'(count), 4);
    check("overflow_head", 32'(wr_addr), 1);

    // Full with push+pop: only the pop happens
    exp_head = 5'd1;
    next_push = 5'd5;
    push_in(32'h105, 5'd5, 1'b0);
    wr_ready = 1'b1;
    check("full_head", wr_data, 32'h101);
    tick();
    exp_head++;
    check("full_pop_count", 32'(count), 3);
    for (int i = 0; i < 4; i++) begin
      push_in(32'h100 + 32'(next_push), next_push, 1'b0);
      check("wrap_head_addr", 32'(wr_addr), 32'(exp_head));
      check("wrap_head_data", wr_data, 32'h100 + 32'(exp_head));
      tick();
      next_push++;
      exp_head++;
      check("wrap_count", 32'(count), 3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain_head_data", wr_data, 32'h100 + 32'(exp_head));
      tick();
      exp_head++;
    end
    check("drain_empty", 32'(count), 0);

    // Forwarding priority and dest-0 exclusion
    wr_ready = 1'b0;
    push_in(32'h11, 5'd7, 1'b0); tick();
    push_in(32'h22, 5'd7, 1'b0); tick();
    push_in(32'h55, 5'd0, 1'b0); tick();
    in_valid = 1'b0;
    rd_addr_a = 5'd7; rd_addr_b = 5'd0;
    #1;
    check("fwd_hit_a", 32'(fwd_hit_a), 1);
    check("fwd_data_a_youngest", fwd_data_a, 32'h22);
    check("fwd_hit_b_zero", 32'(fwd_hit_b), 0);
    check("fwd_data_b_zero", fwd_data_b, 0);
    rd_addr_b = 5'd3;
    #1;
    check("fwd_miss_b", 32'(fwd_hit_b), 0);
    wr_ready = 1'b1;
    tick();
    check("fwd_after_pop_hit", 32'(fwd_hit_a), 1);
    check("popping_head", wr_data, 32'h22);
    tick();
    check("fwd_gone_hit", 32'(fwd_hit_a), 0);
    check("fwd_gone_data", fwd_data_a, 0);
    check("dest0_written_addr", 32'(wr_addr), 0);
    check("dest0_written_data", wr_data, 32'h55);
    tick();
    check("fwd_empty", 32'(count), 0);
    rd_addr_a = '0; rd_addr_b = '0;

    // Zero flag follows pushes only
    wr_ready = 1'b0;
    push_in(32'h0, 5'd9, 1'b1); tick();
    check("zero_set", 32'(zero_flag), 1);
    push_in(32'h5, 5'd10, 1'b0); tick();
    check("zero_clear", 32'(zero_flag), 0);
    push_in(32'h0, 5'd11, 1'b1); tick();
    check("zero_set2", 32'(zero_flag), 1);
    in_valid = 1'b0; in_zero = 1'b0;
    wr_ready = 1'b1;
    tick(); tick(); tick();
    check("zero_hold_pops", 32'(zero_flag), 1);
    check("zero_drained", 32'(count), 0);

    // Asynchronous reset mid-stream
    wr_ready = 1'b0;
    push_in(32'hAA, 5'd1, 1'b0); tick();
    push_in(32'hBB, 5'd2, 1'b0); tick();
    push_in(32'h0, 5'd3, 1'b1); tick();
    in_valid = 1'b0;
    check("pre_reset_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_wr_en", 32'(wr_en), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_zero", 32'(zero_flag), 0);
    rd_addr_a = 5'd2;
    #1;
    check("arst_fwd", 32'(fwd_hit_a), 0);
    #3 rst_n = 1'b1;
    wr_ready = 1'b1;
    tick();
    check("post_reset_wr_en", 32'(wr_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
